// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link: channel count, slot-index type and
// the receive framer state encoding.
package tdm_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] slot_t;

  typedef enum logic {
    HUNT,
    LOCKED
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Enable-gated wrap-around slot counter with synchronous clear and
// load-to-1; usable on both the transmit and receive ends of the link.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  load1,
  input  logic  clr,
  output slot_t slot
);

  // Clear beats load; load beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (load1) begin
      slot <= slot_t'(1);
    end else if (inc) begin
      slot <= slot + slot_t'(1);
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// 8-channel TDM receive demultiplexer: locks to the frame-sync marker,
// gathers one bit per slot and emits a registered parallel word per frame.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int MISS_MAX = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             din,
  output logic [NCH-1:0]   dout,
  output logic             valid,
  output logic [SEL_W-1:0] slot,
  output logic             locked,
  output logic             err
);

  localparam int    MISS_W    = $clog2(MISS_MAX + 1);
  localparam slot_t LAST_SLOT = slot_t'(NCH - 1);

  state_t            state_q, state_d;
  logic [NCH-1:0]    frame_buf_q, frame_buf_d;
  logic [NCH-1:0]    dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              nosync_q, nosync_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              ctr_inc, ctr_load1, ctr_clr;
  slot_t             slot_q;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctr_inc),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .slot  (slot_q)
  );

  always_comb begin
    state_d     = state_q;
    frame_buf_d = frame_buf_q;
    dout_d      = dout_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    nosync_d    = nosync_q;
    miss_d      = miss_q;
    ctr_inc     = 1'b0;
    ctr_load1   = 1'b0;
    ctr_clr     = 1'b0;

    if (en) begin
      case (state_q)
        HUNT: begin
          if (sync) begin
            state_d        = LOCKED;
            frame_buf_d    = '0;
            frame_buf_d[0] = din;
            ctr_load1      = 1'b1;
            miss_d         = '0;
            nosync_d       = 1'b0;
          end
        end
        LOCKED: begin
          if (sync && (slot_q != '0)) begin
            // Misplaced marker: abort the partial frame and restart at slot 1.
            err_d          = 1'b1;
            frame_buf_d    = '0;
            frame_buf_d[0] = din;
            ctr_load1      = 1'b1;
            miss_d         = '0;
            nosync_d       = 1'b0;
          end else begin
            frame_buf_d[slot_q] = din;
            ctr_inc             = 1'b1;
            if (slot_q == '0) begin
              nosync_d = ~sync;
              if (sync) begin
                miss_d = '0;
              end
            end
            if (slot_q == LAST_SLOT) begin
              dout_d  = {din, frame_buf_q[NCH-2:0]};
              valid_d = 1'b1;
              // Flywheel frames are delivered, but too many in a row drop lock.
              if (nosync_q) begin
                if ((int'(miss_q) + 1) >= MISS_MAX) begin
                  state_d = HUNT;
                  ctr_clr = 1'b1;
                  miss_d  = '0;
                end else begin
                  miss_d = miss_q + MISS_W'(1);
                end
              end
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      frame_buf_q <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      nosync_q    <= 1'b0;
      miss_q      <= '0;
    end else begin
      state_q     <= state_d;
      frame_buf_q <= frame_buf_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      nosync_q    <= nosync_d;
      miss_q      <= miss_d;
    end
  end

  assign dout   = dout_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign slot   = slot_q;
  assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: frames are queued as expected words when
// their last slot is driven and compared when valid appears.
module tb_tdm_demux8;
  import tdm_pkg::*;

  logic             clk  = 1'b0;
  logic             rst  = 1'b1;
  logic             en   = 1'b0;
  logic             sync = 1'b0;
  logic             din  = 1'b0;
  logic [NCH-1:0]   dout;
  logic             valid;
  logic [SEL_W-1:0] slot;
  logic             locked;
  logic             err;

  int             total = 0;
  int             bad   = 0;
  logic [NCH-1:0] exp_q[$];
  logic           err_exp = 1'b0;

  always #5 clk = ~clk;

  tdm_demux8 dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sync   (sync),
    .din    (din),
    .dout   (dout),
    .valid  (valid),
    .slot   (slot),
    .locked (locked),
    .err    (err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample_outs();
    if (exp_q.size() != 0) begin
      chk("valid_hi", 32'(valid), 32'd1);
      chk("dout", 32'(dout), 32'(exp_q.pop_front()));
    end else begin
      chk("valid_lo", 32'(valid), 32'd0);
    end
    chk("err", 32'(err), 32'(err_exp));
  endtask

  task automatic strobe(input logic s, input logic d);
    @(negedge clk);
    en = 1'b1; sync = s; din = d;
    @(posedge clk);
    #1;
    sample_outs();
    err_exp = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0; sync = 1'b1; din = 1'b1;
    @(posedge clk);
    #1;
    sample_outs();
  endtask

  task automatic send_frame(input logic [7:0] v, input logic s0, input logic expv, input bit gaps);
    for (int k = 0; k < 8; k++) begin
      if (k == 7 && expv) exp_q.push_back(v);
      strobe((k == 0) ? s0 : 1'b0, v[k]);
      if (gaps && k < 7) begin
        idle();
        chk("gap_slot", 32'(slot), 32'(k + 1));
      end
    end
  endtask

  initial begin
    logic [7:0] f3c;
    f3c = 8'h3C;

    // Reset state
    #12;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_slot", 32'(slot), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic frame, slots 0..7 = 1,0,1,1,0,0,1,0
    send_frame(8'b01001101, 1'b1, 1'b1, 1'b0);
    chk("t1_locked", 32'(locked), 32'd1);
    chk("t1_slot", 32'(slot), 32'd0);
    idle();

    // Two flywheel frames drop lock on the second completion
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
    chk("t4_locked_a", 32'(locked), 32'd1);
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    chk("t4_locked_b", 32'(locked), 32'd0);
    chk("t4_slot_b", 32'(slot), 32'd0);
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    chk("t4_slot_c", 32'(slot), 32'd0);
    chk("t4_locked_c", 32'(locked), 32'd0);

    // Hunting without sync, then a synced frame
    for (int i = 0; i < 5; i++) strobe(1'b0, 1'b1);
    chk("t2_slot", 32'(slot), 32'd0);
    chk("t2_locked", 32'(locked), 32'd0);
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    chk("t2_locked_after", 32'(locked), 32'd1);

    // Misplaced sync at slot 3 restarts the frame
    strobe(1'b1, 1'b1);
    strobe(1'b0, 1'b0);
    strobe(1'b0, 1'b1);
    err_exp = 1'b1;
    strobe(1'b1, f3c[0]);
    chk("t3_slot", 32'(slot), 32'd1);
    chk("t3_locked", 32'(locked), 32'd1);
    for (int k = 1; k < 8; k++) begin
      if (k == 7) exp_q.push_back(f3c);
      strobe(1'b0, f3c[k]);
    end

    // Gapped strobes
    send_frame(8'h96, 1'b1, 1'b1, 1'b1);
    idle();
    chk("t5_dout_hold", 32'(dout), 32'h96);

    // Asynchronous reset mid-frame
    for (int k = 0; k < 4; k++) strobe((k == 0) ? 1'b1 : 1'b0, 1'b1);
    chk("t6_slot_pre", 32'(slot), 32'd4);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_slot", 32'(slot), 32'd0);
    chk("t6_locked", 32'(locked), 32'd0);
    chk("t6_dout", 32'(dout), 32'h0);
    chk("t6_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    chk("t6_locked_after", 32'(locked), 32'd1);
    idle();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive-side counterpart of the 8:1 gate-level data-select mux. Recovers eight single-bit channels from a time-division-multiplexed serial stream.
- At the transmit end, a 3-bit slot counter drives the mux select lines. This block tracks the same slot sequence from a frame-sync marker, deposits each slot bit into its channel, and presents all eight channels as a registered parallel word once per frame.
- Sits between the serial link input and channel-level consumer logic.

Parameters:
- NCH, 8, channels (slots) per frame; fixed at 8 for this release.
- SEL_W, 3, slot-index width, equal to log2(NCH).
- MISS_MAX, 2, consecutive frames completed without sync at slot 0 before dropping lock.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  slot strobe; din and sync sampled only when en=1.
- sync  input  1  frame marker; asserted with en on slot 0 of each frame.
- din  input  1  serial TDM data bit.
- dout  output  NCH  recovered channels; dout[k] = slot k.
- valid  output  1  one-cycle pulse: new frame on dout.
- slot  output  SEL_W  index of the next slot expected.
- locked  output  1  1 while in LOCKED.
- err  output  1  one-cycle pulse on framing error.

Behaviour:
- Slot numbering matches the transmit mux select encoding (s0 = MSB, s2 = LSB). Slot value k (0..7) maps to channel Dk and to dout[k].
- Reset, asynchronous, effective immediately:
  - state=HUNT; slot=0; miss_cnt=0.
  - Internal buffer=0; dout=0; valid=0; locked=0; err=0.
- Reset mid-frame discards the partial buffer and does not produce valid.
- Cycles with en=0 change nothing except clearing valid/err to 0. sync with en=0 is ignored.
- HUNT:
  - en=1 && sync=1: buf[0]<=din, slot<=1, go LOCKED, locked<=1.
  - All other en cycles are ignored; slot stays 0.
- LOCKED, on each en=1 cycle:
  - sync=1 && slot!=0: framing error.
    - err<=1 for one cycle; partial buffer discarded (bits 1..7 cleared).
    - Resynchronise: buf[0]<=din, slot<=1, miss_cnt<=0.
    - No valid is produced for the aborted frame.
  - Otherwise: buf[slot]<=din, slot<=slot+1 (wraps 7→0).
  - sync=1 at slot 0 resets miss_cnt to 0. sync=0 at slot 0 is tolerated (flywheel), with miss handling below.
- Frame completion: the en cycle at slot 7 with no error. At that same edge:
  - dout<={din, buf[6:0]}; valid<=1 for exactly one cycle.
  - slot wraps to 0.
- Latency: dout/valid update on the clock edge that samples slot 7, i.e. visible the cycle after the slot-7 strobe. dout holds until the next completion or reset.
- Miss handling:
  - When a frame completes whose slot 0 was taken without sync, miss_cnt increments.
  - When miss_cnt reaches MISS_MAX, the state goes to HUNT at that same edge: locked<=0, slot<=0, miss_cnt<=0.
  - The completing frame is still delivered (valid=1).
- Simultaneous events: sync at slot 0 in LOCKED is normal, not an error. err and valid never assert in the same cycle.
- Back-to-back en every cycle: sustained throughput of one frame per 8 cycles.

Decomposition:
- Shared package tdm_pkg holds:
  - NCH, SEL_W constants.
  - State enum {HUNT, LOCKED}.
  - Slot-index typedef, also used by the transmit-side slot counter.
- One natural sub-module: tdm_slot_ctr.
  - Contains the enable-gated, wrap-around SEL_W-bit counter with synchronous load-to-1 and clear.
  - Shareable with the transmit side.
- The buffer, FSM and miss counter stay in tdm_demux8.

Test Plan:
1. Reset, then continuous en; frame with sync at slot 0 and bits slot0..7 = 1,0,1,1,0,0,1,0 → one cycle after the slot-7 strobe: dout=8'b01001101, valid=1 for 1 cycle, locked=1, slot=0.
2. In HUNT, 5 en strobes without sync → slot stays 0, no valid, locked=0. Then sync plus frame 0xA5 (LSB = slot 0) → dout=8'hA5.
3. While locked, assert sync at slot 3 → err pulse 1 cycle, no valid. Next 7 strobes complete a frame of 0x3C started at the resync bit → dout=8'h3C, err=0.
4. Locked, then two consecutive frames with sync=0 at slot 0 (MISS_MAX=2) → both frames produce valid. locked drops to 0 on the second completion edge; further frames are ignored until sync.
5. en toggled 1-0-1-0 during a frame → slot advances only on en=1; valid occurs 1 cycle after the 8th strobe; data is unchanged vs. continuous en.
6. Assert rst asynchronously (between edges) at slot 4 → outputs and slot clear immediately, locked=0. After release, a fresh sync frame 0xFF yields dout=8'hFF with no leftover bits.
